// File: rtl/instr_mem_loader_if.sv
// Byte-stream / instruction-memory write bundle for instr_mem_loader.
// master = stream source and status consumer, slave = the loader itself.
interface instr_mem_loader_if #(
    parameter int unsigned WORD_W = 72,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a byte stream MSB-first into instruction words and writes them from address 0 while holding the core.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned WORD_W = 72,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input logic               clk,
    input logic               rst,
    instr_mem_loader_if.slave bus
);
    localparam int unsigned     BPW     = WORD_W / BYTE_W;
    localparam int unsigned     BCW     = $clog2(BPW);
    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [ADDR_W:0] r_n, r_wcnt, w_wcnt_inc, w_n;
    logic [BCW-1:0]  r_bcnt;
    logic [WORD_W-1:0] r_shift;
    logic            r_busy, r_done;
    logic            w_ready, w_we, w_accept, w_last_byte;

    assign w_n         = (bus.word_count > DEPTH_N) ? DEPTH_N : bus.word_count;
    assign w_accept    = bus.byte_valid & w_ready;
    assign w_last_byte = (r_bcnt == BCW'(BPW - 1));
    assign w_wcnt_inc  = r_wcnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = (w_n == '0) ? S_DONE : S_RECV;
            end
            S_RECV: begin
                w_ready = 1'b1;
                if (bus.byte_valid && w_last_byte) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_we = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                w_next = (w_wcnt_inc == r_n) ? S_CHECK : S_RECV;
`else
                w_next = (w_wcnt_inc == r_n) ? S_DONE : S_RECV;
`endif
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_ready = 1'b1;
                if (bus.byte_valid) w_next = S_DONE;
            end
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n     <= '0;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_n    <= w_n;
                        r_wcnt <= '0;
                        r_bcnt <= '0;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_shift <= {r_shift[WORD_W-BYTE_W-1:0], bus.byte_in};
                        r_bcnt  <= w_last_byte ? '0 : r_bcnt + 1'b1;
                    end
                end
                S_WRITE: r_wcnt <= w_wcnt_inc;
                S_DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_xsum;
    logic              r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xsum  <= '0;
            r_error <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_xsum  <= '0;
            r_error <= 1'b0;
        end else if (r_state == S_RECV && w_accept) begin
            r_xsum  <= r_xsum ^ bus.byte_in;
        end else if (r_state == S_CHECK && w_accept) begin
            r_error <= (bus.byte_in != r_xsum);
        end
    end

    assign bus.error = r_error;
`else
    assign bus.error = 1'b0;
`endif

    // Address/data are forced to zero outside WRITE so the counter's terminal value never shows on the bus.
    assign bus.byte_ready = w_ready;
    assign bus.imem_we    = w_we;
    assign bus.imem_addr  = w_we ? r_wcnt[ADDR_W-1:0] : '0;
    assign bus.imem_wdata = w_we ? r_shift : '0;
    assign bus.cpu_hold   = r_busy;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised self-checking bench for instr_mem_loader (small DEPTH to exercise clamping).
// Honours INSTR_LOADER_CHECKSUM_EN the same way as the design.
module tb_instr_mem_loader;
    localparam int unsigned WORD_W = 72;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned BPW    = WORD_W / BYTE_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.WORD_W(WORD_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(
        .WORD_W(WORD_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model state: expected words in write order, words/bytes seen this load.
    logic [WORD_W-1:0] exp_q[$];
    int unsigned       m_n   = 0;
    int unsigned       m_cnt = 0;
    int unsigned       m_wr  = 0;
    logic              m_pend = 1'b0;
    logic [WORD_W-1:0] last_wdata = '0;
    logic [7:0]        src [DEPTH*BPW];

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_we", WORD_W'(bus.imem_we), '0);
            chk("rst_ready", WORD_W'(bus.byte_ready), '0);
            chk("rst_busy", WORD_W'(bus.busy), '0);
            chk("rst_done", WORD_W'(bus.done), '0);
            m_pend = 1'b0;
            m_cnt  = 0;
            m_n    = 0;
        end else begin
            chk("we_timing", WORD_W'(bus.imem_we), WORD_W'(m_pend));
            if (bus.imem_we) begin
                chk("ready_in_write", WORD_W'(bus.byte_ready), '0);
                chk("waddr", WORD_W'(bus.imem_addr), WORD_W'(m_wr));
                chk("write_expected", WORD_W'(exp_q.size() != 0), WORD_W'(1));
                if (exp_q.size() != 0) chk("wdata", bus.imem_wdata, exp_q.pop_front());
                last_wdata = bus.imem_wdata;
                m_wr++;
            end
            m_pend = 1'b0;
            if (bus.byte_valid && bus.byte_ready && m_cnt < m_n * BPW) begin
                m_cnt++;
                if (m_cnt % BPW == 0) m_pend = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned t;
        bus.byte_valid = 1'b0;
        repeat (gap) tick();
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (!bus.byte_ready && t < 200) begin
            tick();
            t++;
        end
        if (t == 200) chk("ready_timeout", WORD_W'(bus.byte_ready), WORD_W'(1));
        tick();
        bus.byte_valid = 1'b0;
    endtask

    function automatic int unsigned pick_gap(input int unsigned mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return $urandom_range(0, 3);
    endfunction

    // gapmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
    task automatic run_load(input int unsigned n, input int unsigned gapmode,
                            input bit bad_cks, input bit pulse_busy);
        int unsigned       ne;
        int unsigned       t;
        logic [WORD_W-1:0] w;
        logic [7:0]        x;
        logic              exp_err;
        ne = (n > DEPTH) ? DEPTH : n;
        x  = '0;
        exp_q = {};
        for (int i = 0; i < int'(ne); i++) begin
            w = '0;
            for (int j = 0; j < int'(BPW); j++) begin
                w = w * 256 + WORD_W'(src[i*BPW+j]);
                x = x ^ src[i*BPW+j];
            end
            exp_q.push_back(w);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        exp_err = bad_cks && (ne > 0);
`else
        exp_err = 1'b0;
`endif
        m_n = ne; m_cnt = 0; m_wr = 0;
        bus.word_count = (ADDR_W + 1)'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", WORD_W'(bus.busy), WORD_W'(1));
        chk("hold_after_start", WORD_W'(bus.cpu_hold), WORD_W'(1));
        chk("done_cleared", WORD_W'(bus.done), '0);
        chk("error_cleared", WORD_W'(bus.error), '0);
        if (ne == 0) begin
            tick();
            chk("n0_done_2cyc", WORD_W'(bus.done), WORD_W'(1));
        end
        for (int k = 0; k < int'(ne * BPW); k++) begin
            send_byte(src[k], pick_gap(gapmode));
            if (pulse_busy && k == 0) begin
                bus.word_count = (ADDR_W + 1)'(1);
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (ne > 0) send_byte(bad_cks ? (x ^ 8'h01) : x, pick_gap(gapmode));
`endif
        t = 0;
        while (!bus.done && t < 100) begin
            tick();
            t++;
        end
        chk("done", WORD_W'(bus.done), WORD_W'(1));
        chk("busy_end", WORD_W'(bus.busy), '0);
        chk("hold_end", WORD_W'(bus.cpu_hold), '0);
        chk("error", WORD_W'(bus.error), WORD_W'(exp_err));
        chk("write_count", WORD_W'(m_wr), WORD_W'(ne));
        chk("queue_empty", WORD_W'(exp_q.size()), '0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < int'(DEPTH * BPW); k++) src[k] = 8'($urandom);
    endtask

    task automatic fill_count();
        for (int k = 0; k < int'(DEPTH * BPW); k++) src[k] = 8'(k + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.word_count = '0;
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single word 01..09
        fill_count();
        run_load(1, 0, 1'b0, 1'b0);
        chk("wdata_literal", last_wdata, 72'h010203040506070809);

        // three words, valid toggling, start pulsed mid-load
        fill_random();
        run_load(3, 1, 1'b0, 1'b1);

        // N=0, with a start pulse while still busy
        m_n = 0; m_cnt = 0; m_wr = 0; exp_q = {};
        bus.word_count = '0;
        bus.start = 1'b1;
        tick();
        chk("n0_busy", WORD_W'(bus.busy), WORD_W'(1));
        chk("n0_done_low", WORD_W'(bus.done), '0);
        bus.word_count = (ADDR_W + 1)'(3);
        tick();
        bus.start = 1'b0;
        chk("n0_done_2cyc", WORD_W'(bus.done), WORD_W'(1));
        chk("n0_busy_low", WORD_W'(bus.busy), '0);
        repeat (12) tick();
        chk("n0_ignored_start", WORD_W'(bus.busy), '0);
        chk("n0_no_writes", WORD_W'(m_wr), '0);

        // reset after 5 bytes of the first word
        fill_random();
        m_n = 1; m_cnt = 0; m_wr = 0; exp_q = {};
        bus.word_count = (ADDR_W + 1)'(1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) send_byte(src[k], 0);
        rst = 1'b1;
        #1;
        chk("arst_we", WORD_W'(bus.imem_we), '0);
        chk("arst_ready", WORD_W'(bus.byte_ready), '0);
        chk("arst_addr", WORD_W'(bus.imem_addr), '0);
        chk("arst_wdata", bus.imem_wdata, '0);
        chk("arst_hold", WORD_W'(bus.cpu_hold), '0);
        chk("arst_busy", WORD_W'(bus.busy), '0);
        chk("arst_done", WORD_W'(bus.done), '0);
        chk("arst_error", WORD_W'(bus.error), '0);
        tick();
        rst = 1'b0;
        tick();
        fill_random();
        run_load(1, 2, 1'b0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        fill_count();
        run_load(1, 0, 1'b0, 1'b0);
        fill_count();
        run_load(1, 0, 1'b1, 1'b0);
        chk("cks_bad_data", last_wdata, 72'h010203040506070809);
`endif

        // word count beyond DEPTH is clamped
        fill_random();
        run_load(DEPTH + 5, 2, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_load($urandom_range(0, 7), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
